// File: rtl/de_stage_pkg.sv
// Shared LC-3b types for the decode stage: register ids, control-word bit
// positions and the decode FSM state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [19:0] lc3b_twenty;
    typedef logic [2:0]  lc3b_nzp;

    localparam int CS_LD_REG = 0;
    localparam int CS_SR1    = 1;
    localparam int CS_SR2    = 2;
    localparam int CS_SR_ST  = 3;
    localparam int CS_LD_CC  = 4;
    localparam int CS_CTRL   = 5;
    localparam int CS_DR_R7  = 6;
    localparam int CS_RD_CC  = 7;

    localparam lc3b_nzp CC_RESET = 3'b010;

    typedef enum logic {
        DE_RUN     = 1'b0,
        DE_WAIT_BR = 1'b1
    } de_state_t;

    function automatic logic [7:0] reg_onehot(input lc3b_reg id);
        return 8'b1 << id;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 8x16 architectural register file: one write port, three write-first read
// ports so a same-cycle writeback is visible to the reading instruction.
module regfile_bypass
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_id,
    input  logic [15:0] wr_data,
    input  logic [2:0]  rd1_id,
    input  logic [2:0]  rd2_id,
    input  logic [2:0]  rd3_id,
    output logic [15:0] rd1_data,
    output logic [15:0] rd2_data,
    output logic [15:0] rd3_data
);

    logic [7:0][15:0] regs;

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[wr_id] <= wr_data;
        end
    end

    assign rd1_data = (wr_en && wr_id == rd1_id) ? wr_data : regs[rd1_id];
    assign rd2_data = (wr_en && wr_id == rd2_id) ? wr_data : regs[rd2_id];
    assign rd3_data = (wr_en && wr_id == rd3_id) ? wr_data : regs[rd3_id];

endmodule

// File: rtl/de_stage.sv
// LC-3b decode / register-read stage: operand read, busy scoreboard for
// RAW/WAW hazards, branch stall, and the AGEX pipeline latch.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   DE_RUN     | issuing normally whenever no hazard and AGEX not stalled
//   DE_WAIT_BR | control instruction in flight; hold issue until resolve
module de_stage
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        de_valid_in,
    output logic        de_ready_out,
    input  logic [15:0] de_npc_in,
    input  logic [15:0] de_ir_in,
    input  logic [19:0] de_cs_in,
    input  logic        agex_stall_in,
    input  logic        br_resolve,
    input  logic        wb_en,
    input  logic [2:0]  wb_drid,
    input  logic [15:0] wb_data,
    input  logic        wb_ld_cc,
    input  logic [2:0]  wb_cc,
    output logic        agex_valid_out,
    output logic [15:0] agex_npc_out,
    output logic [15:0] agex_ir_out,
    output logic [15:0] agex_sr1_out,
    output logic [15:0] agex_sr2_out,
    output logic [19:0] agex_cs_out,
    output logic [2:0]  agex_cc_out,
    output logic [2:0]  agex_drid_out
);

    de_state_t  state, state_nxt;
    logic [7:0] busy, busy_p, busy_nxt, wb_clr;
    logic       cc_busy, cc_busy_p, cc_busy_nxt;
    lc3b_nzp    cc_q, cc_rd;
    lc3b_reg    sr1_id, sr2_id, st_id, drid;
    lc3b_word   sr1_val, sr2_val, st_val;
    logic       hazard, issue;

    assign sr1_id = de_ir_in[8:6];
    assign sr2_id = de_ir_in[2:0];
    assign st_id  = de_ir_in[11:9];
    assign drid   = de_cs_in[CS_DR_R7] ? 3'd7 : de_ir_in[11:9];

    regfile_bypass u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_en),
        .wr_id    (wb_drid),
        .wr_data  (wb_data),
        .rd1_id   (sr1_id),
        .rd2_id   (sr2_id),
        .rd3_id   (st_id),
        .rd1_data (sr1_val),
        .rd2_data (sr2_val),
        .rd3_data (st_val)
    );

    // Writebacks retire first, so a dependent can issue in the writeback cycle.
    assign wb_clr    = wb_en ? reg_onehot(wb_drid) : 8'h00;
    assign busy_p    = busy & ~wb_clr;
    assign cc_busy_p = cc_busy & ~wb_ld_cc;
    assign cc_rd     = wb_ld_cc ? wb_cc : cc_q;

    assign hazard = (de_cs_in[CS_SR1]    & busy_p[sr1_id])
                  | (de_cs_in[CS_SR2]    & busy_p[sr2_id])
                  | (de_cs_in[CS_SR_ST]  & busy_p[st_id])
                  | (de_cs_in[CS_LD_REG] & busy_p[drid])
                  | (de_cs_in[CS_RD_CC]  & cc_busy_p);

    assign issue        = de_valid_in & (state == DE_RUN) & ~agex_stall_in & ~hazard;
    assign de_ready_out = issue;

    // An issuing destination set wins over a same-cycle writeback clear.
    assign busy_nxt    = busy_p | ((issue & de_cs_in[CS_LD_REG]) ? reg_onehot(drid) : 8'h00);
    assign cc_busy_nxt = cc_busy_p | (issue & de_cs_in[CS_LD_CC]);

    always_comb begin
        state_nxt = state;
        case (state)
            DE_RUN:     if (issue && de_cs_in[CS_CTRL]) state_nxt = DE_WAIT_BR;
            DE_WAIT_BR: if (br_resolve)                 state_nxt = DE_RUN;
            default:                                    state_nxt = DE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= DE_RUN;
            busy    <= '0;
            cc_busy <= 1'b0;
            cc_q    <= CC_RESET;
        end else begin
            state   <= state_nxt;
            busy    <= busy_nxt;
            cc_busy <= cc_busy_nxt;
            if (wb_ld_cc) cc_q <= wb_cc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            agex_valid_out <= 1'b0;
            agex_npc_out   <= '0;
            agex_ir_out    <= '0;
            agex_sr1_out   <= '0;
            agex_sr2_out   <= '0;
            agex_cs_out    <= '0;
            agex_cc_out    <= '0;
            agex_drid_out  <= '0;
        end else if (issue) begin
            agex_valid_out <= 1'b1;
            agex_npc_out   <= de_npc_in;
            agex_ir_out    <= de_ir_in;
            agex_sr1_out   <= sr1_val;
            agex_sr2_out   <= de_cs_in[CS_SR_ST] ? st_val : sr2_val;
            agex_cs_out    <= de_cs_in;
            agex_cc_out    <= cc_rd;
            agex_drid_out  <= drid;
        end else if (!agex_stall_in) begin
            agex_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_de_stage.sv
// Scoreboard bench for de_stage: the driver pushes hand-computed AGEX latch
// contents on each expected issue, and a negedge monitor pops and compares.
module tb_de_stage;

    typedef struct packed {
        logic [15:0] npc;
        logic [15:0] ir;
        logic [15:0] sr1;
        logic [15:0] sr2;
        logic [19:0] cs;
        logic [2:0]  cc;
        logic [2:0]  drid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        de_valid_in = 1'b0;
    logic        de_ready_out;
    logic [15:0] de_npc_in = '0;
    logic [15:0] de_ir_in = '0;
    logic [19:0] de_cs_in = '0;
    logic        agex_stall_in = 1'b0;
    logic        br_resolve = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_drid = '0;
    logic [15:0] wb_data = '0;
    logic        wb_ld_cc = 1'b0;
    logic [2:0]  wb_cc = '0;
    logic        agex_valid_out;
    logic [15:0] agex_npc_out, agex_ir_out, agex_sr1_out, agex_sr2_out;
    logic [19:0] agex_cs_out;
    logic [2:0]  agex_cc_out, agex_drid_out;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t last_exp;
    exp_t e0 = '0;
    logic pending = 1'b0;

    always #5 clk = ~clk;

    de_stage dut (
        .clk            (clk),
        .reset          (reset),
        .de_valid_in    (de_valid_in),
        .de_ready_out   (de_ready_out),
        .de_npc_in      (de_npc_in),
        .de_ir_in       (de_ir_in),
        .de_cs_in       (de_cs_in),
        .agex_stall_in  (agex_stall_in),
        .br_resolve     (br_resolve),
        .wb_en          (wb_en),
        .wb_drid        (wb_drid),
        .wb_data        (wb_data),
        .wb_ld_cc       (wb_ld_cc),
        .wb_cc          (wb_cc),
        .agex_valid_out (agex_valid_out),
        .agex_npc_out   (agex_npc_out),
        .agex_ir_out    (agex_ir_out),
        .agex_sr1_out   (agex_sr1_out),
        .agex_sr2_out   (agex_sr2_out),
        .agex_cs_out    (agex_cs_out),
        .agex_cc_out    (agex_cc_out),
        .agex_drid_out  (agex_drid_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] npc, input logic [15:0] ir, input logic [19:0] cs,
                                input logic [15:0] sr1, input logic [15:0] sr2,
                                input logic [2:0] cc, input logic [2:0] drid);
        exp_t e;
        e.npc = npc; e.ir = ir; e.cs = cs; e.sr1 = sr1; e.sr2 = sr2; e.cc = cc; e.drid = drid;
        return e;
    endfunction

    task automatic chk_outputs(input string tag, input logic valid, input exp_t e);
        chk({tag, "_valid"}, {31'b0, agex_valid_out}, {31'b0, valid});
        chk({tag, "_npc"},   {16'b0, agex_npc_out},   {16'b0, e.npc});
        chk({tag, "_ir"},    {16'b0, agex_ir_out},    {16'b0, e.ir});
        chk({tag, "_sr1"},   {16'b0, agex_sr1_out},   {16'b0, e.sr1});
        chk({tag, "_sr2"},   {16'b0, agex_sr2_out},   {16'b0, e.sr2});
        chk({tag, "_cs"},    {12'b0, agex_cs_out},    {12'b0, e.cs});
        chk({tag, "_cc"},    {29'b0, agex_cc_out},    {29'b0, e.cc});
        chk({tag, "_drid"},  {29'b0, agex_drid_out},  {29'b0, e.drid});
    endtask

    // One cycle of stimulus; inputs change #1 after the rising edge.
    task automatic cyc(input logic v, input logic [15:0] npc, input logic [15:0] ir, input logic [19:0] cs,
                       input logic stl, input logic brr,
                       input logic we, input logic [2:0] wd, input logic [15:0] wdat,
                       input logic lcc, input logic [2:0] wcc,
                       input logic exp_rdy, input exp_t e);
        de_valid_in = v; de_npc_in = npc; de_ir_in = ir; de_cs_in = cs;
        agex_stall_in = stl; br_resolve = brr;
        wb_en = we; wb_drid = wd; wb_data = wdat; wb_ld_cc = lcc; wb_cc = wcc;
        @(negedge clk);
        chk("ready", {31'b0, de_ready_out}, {31'b0, exp_rdy});
        if (stl) chk_outputs("stall_hold", 1'b1, last_exp);
        if (exp_rdy) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 16'h0, 16'h0, 20'h0, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (pending) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk_outputs("issue", 1'b1, e);
                end
            end
            pending = de_ready_out && !reset;
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_outputs("reset", 1'b0, e0);
        @(posedge clk);
        #1;

        // ADD R1,R2,R3
        cyc(1, 16'h3002, 16'h1283, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1,
            mk(16'h3002, 16'h1283, 20'h17, 16'h0, 16'h0, 3'b010, 3'd1));
        // ADD R4,R1,R1: RAW on R1 until the writeback cycle
        cyc(1, 16'h3004, 16'h1841, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3004, 16'h1841, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3004, 16'h1841, 20'h17, 0, 0, 1, 3'd1, 16'h1234, 0, 3'd0, 1,
            mk(16'h3004, 16'h1841, 20'h17, 16'h1234, 16'h1234, 3'b010, 3'd4));
        // BR reads CC: blocked by cc_busy, then released by a same-cycle CC writeback
        cyc(1, 16'h3006, 16'h0E05, 20'hA0, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3006, 16'h0E05, 20'hA0, 0, 0, 0, 3'd0, 16'h0, 1, 3'b001, 1,
            mk(16'h3006, 16'h0E05, 20'hA0, 16'h0, 16'h0, 3'b001, 3'd7));
        // WAIT_BR: held until the cycle after br_resolve
        cyc(1, 16'h3008, 16'h1400, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3008, 16'h1400, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3008, 16'h1400, 20'h17, 0, 1, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3008, 16'h1400, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1,
            mk(16'h3008, 16'h1400, 20'h17, 16'h0, 16'h0, 3'b001, 3'd2));
        // AGEX stall for 3 cycles; writeback to R5 still lands
        repeat (3)
            cyc(1, 16'h300A, 16'h1641, 20'h17, 1, 0, 1, 3'd5, 16'h5555, 0, 3'd0, 0, e0);
        cyc(1, 16'h300A, 16'h1641, 20'h17, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1,
            mk(16'h300A, 16'h1641, 20'h17, 16'h1234, 16'h1234, 3'b001, 3'd3));
        cyc(1, 16'h300C, 16'h1D45, 20'h07, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1,
            mk(16'h300C, 16'h1D45, 20'h07, 16'h5555, 16'h5555, 3'b001, 3'd6));
        // Store source R3 busy, then bypassed from the writeback
        cyc(1, 16'h300E, 16'h7600, 20'h0A, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h300E, 16'h7600, 20'h0A, 0, 0, 1, 3'd3, 16'hBEEF, 0, 3'd0, 1,
            mk(16'h300E, 16'h7600, 20'h0A, 16'h0, 16'hBEEF, 3'b001, 3'd3));
        // JSR with same-cycle writeback to R7: busy[7] must remain set
        cyc(1, 16'h3010, 16'h4802, 20'h61, 0, 0, 1, 3'd7, 16'h7777, 0, 3'd0, 1,
            mk(16'h3010, 16'h4802, 20'h61, 16'h0, 16'h0, 3'b001, 3'd7));
        cyc(1, 16'h3012, 16'h11C7, 20'h07, 0, 1, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3012, 16'h11C7, 20'h07, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 0, e0);
        cyc(1, 16'h3012, 16'h11C7, 20'h07, 0, 0, 1, 3'd7, 16'h0707, 0, 3'd0, 1,
            mk(16'h3012, 16'h11C7, 20'h07, 16'h0707, 16'h0707, 3'b001, 3'd0));
        // Enter WAIT_BR with busy bits set, then reset overriding writebacks
        cyc(1, 16'h3014, 16'h4802, 20'h61, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1,
            mk(16'h3014, 16'h4802, 20'h61, 16'h0, 16'h0, 3'b001, 3'd7));
        reset = 1'b1;
        cyc(1, 16'h3016, 16'h11C7, 20'h07, 0, 0, 1, 3'd7, 16'hFFFF, 1, 3'b100, 0, e0);
        reset = 1'b0;
        de_valid_in = 1'b0; wb_en = 1'b0; wb_ld_cc = 1'b0;
        @(negedge clk);
        chk_outputs("post_reset", 1'b0, e0);
        @(posedge clk);
        #1;
        // RUN with clean scoreboard, zeroed registers and CC=010
        cyc(1, 16'h3016, 16'h11C7, 20'h07, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1,
            mk(16'h3016, 16'h11C7, 20'h07, 16'h0, 16'h0, 3'b010, 3'd0));
        idle();
        idle();
        chk("queue_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/de_stage.md
# de_stage

Decode/register-read stage of the pipelined LC-3b core. It sits between the fetch-stage latch and the AGEX pipeline latch. It holds the 8×16 architectural register file and the condition-code register, reads source operands, and blocks RAW/WAW hazards with a per-register busy scoreboard. After a control instruction it stalls until the branch resolves, then loads the AGEX latch contents (npc, cs, ir, sr1, sr2, cc, drid) with a valid bit.

## Interface
Parameters: none; all widths come from `lc3b_types`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `de_valid_in`  in  1  fetch presents an instruction
- `de_ready_out`  out  1  instruction accepted this cycle (combinational)
- `de_npc_in`  in  16  PC+2 of the instruction
- `de_ir_in`  in  16  instruction word
- `de_cs_in`  in  20  control word from the external control store for `de_ir_in`
- `agex_stall_in`  in  1  AGEX cannot accept; hold the outputs
- `br_resolve`  in  1  one-cycle pulse: outstanding control instruction resolved
- `wb_en`  in  1  register writeback
- `wb_drid`  in  3  writeback destination register
- `wb_data`  in  16  writeback data
- `wb_ld_cc`  in  1  CC writeback
- `wb_cc`  in  3  new nzp
- `agex_valid_out`  out  1  AGEX latch holds a live instruction
- `agex_npc_out`, `agex_ir_out`, `agex_sr1_out`, `agex_sr2_out`  out  16  latched npc, ir, SR1 value, SR2/store-source value
- `agex_cs_out`  out  20  latched control word
- `agex_cc_out`, `agex_drid_out`  out  3  latched nzp, destination register id

## Operation
Control-word bits used here:
- cs[0] ld_reg, cs[1] uses SR1 = IR[8:6], cs[2] uses SR2 = IR[2:0]
- cs[3] uses the store source IR[11:9], cs[4] ld_cc, cs[5] control instruction
- cs[6] DR = R7, cs[7] reads CC
- All other bits pass through unchanged.

Destination and register file:
- drid = cs[6] ? 3'd7 : IR[11:9].
- Register reads are write-first: a same-cycle `wb_en` to the read register returns `wb_data`. The CC read behaves the same way.

Scoreboard:
- busy[7:0] and cc_busy.
- busy′ is busy with the same-cycle writeback bits cleared.

Hazard condition — any of:
- cs[1] & busy′[IR[8:6]]
- cs[2] & busy′[IR[2:0]]
- cs[3] & busy′[IR[11:9]]
- cs[0] & busy′[drid] (WAW)
- cs[7] & cc_busy′

Issue:
- issue = de_valid_in & state==RUN & ~agex_stall_in & ~hazard; `de_ready_out` = issue.
- On issue, load all agex_* outputs and set agex_valid_out=1.
- sr2_out = cs[3] ? R[IR[11:9]] : R[IR[2:0]].
- Busy update on issue: set busy[drid] if cs[0], set cc_busy if cs[4]. A set wins over a same-cycle clear of the same bit.
- No issue and ~agex_stall_in → agex_valid_out<=0 (bubble); the other outputs are don't-care.
- agex_stall_in → all agex_* outputs hold.

FSM:
- RUN → WAIT_BR on issue with cs[5].
- WAIT_BR → RUN on br_resolve.
- br_resolve in RUN is ignored.
- Writebacks are always accepted in both states.

## Timing
Reset values:
- All registers R0–R7 = 0, CC = 3'b010, busy = 0, cc_busy = 0, state = RUN.
- agex_valid_out = 0; every other agex_* output = 0.

Latency and throughput:
- Accept-to-output latency is 1 cycle.
- Throughput is 1 instruction per cycle when hazard-free.

Writeback and hazards:
- A writeback in cycle t releases a dependent instruction in cycle t, because the hazard check uses busy′ and the read uses bypass.

Control instructions:
- A control instruction issued at t blocks issue during WAIT_BR.
- br_resolve at t+k lets the next issue occur at t+k+1 at the earliest.

Boundary cases:
- Writeback to R7 with a simultaneous JSR issue: busy[7] ends at 1.
- Reset mid-operation: discards WAIT_BR, the scoreboard and the output valid the next edge.
- Reset overrides issue and writeback.

## Structure
- Add to `lc3b_types`: `lc3b_reg` (3-bit), `lc3b_twenty`, `lc3b_nzp`, the cs bit-index constants (CS_LD_REG … CS_RD_CC), and the `de_state_t` enum.
- One sub-module: `regfile_bypass` (8×16 storage, write port, three write-first read ports: SR1, SR2, store-source).
- The scoreboard, FSM and output registers stay in `de_stage`.

## Test plan
1. Reset, then issue ADD R1,R2,R3 (cs[0,1,2,4]) → next cycle agex_valid_out=1, agex_drid_out=1, sr1_out=0, busy[1]=1, cc_busy=1.
2. ADD R1←… then immediately ADD R4,R1,R1 → de_ready_out=0 until wb_en,wb_drid=1,wb_data=16'h1234; issue that same cycle, with sr1_out=sr2_out=16'h1234 next cycle.
3. BR (cs[5,7]) issued → following instructions held with de_ready_out=0; br_resolve at cycle 5 → next instruction issues at cycle 6.
4. agex_stall_in held 3 cycles with a valid output → all agex_* outputs unchanged; de_ready_out=0; writebacks still update registers.
5. JSR (cs[0,5,6]) with a same-cycle wb_en to R7 → agex_drid_out=7, busy[7]=1 afterwards.
6. Reset asserted while in WAIT_BR with busy=8'hFF → next cycle state RUN, busy=0, agex_valid_out=0, CC=3'b010.
